// File: rtl/fxp_seq_mul.sv
// fxp_seq_mul -- sequential signed fixed-point multiplier (shift-add, one bit
// of |b| per clock, LSB first).
//
// Operands are two's complement. The block works on magnitudes and applies
// the recorded sign at the end, so the product is exact for every pair,
// including -2^(A-1) * -2^(B-1). In Qn.f terms the binary point of o_mul sits
// at fa+fb.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (i_valid/o_ready on the operand side, o_valid/i_ready on the
// product side). Valid never depends on ready. Once o_valid rises, o_valid and
// o_mul hold until the consumer takes the product. The block never accepts
// operands on the same edge that it hands over a product.
//
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous, active-high reset
//   i_valid  operand pair offered
//   o_ready  operands can be accepted (high only in IDLE)
//   i_a      signed multiplicand, A bits
//   i_b      signed multiplier, B bits
//   o_valid  product available (DONE state)
//   i_ready  consumer takes the product
//   o_mul    registered signed product, MUL_O = A+B bits
//   o_busy   debug: high while the shift-add loop is running
module fxp_seq_mul #(
  parameter int A     = 8,
  parameter int B     = 8,
  parameter int MUL_O = A + B
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [A-1:0]     i_a,
  input  logic [B-1:0]     i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [MUL_O-1:0] o_mul,
  output logic             o_busy
);

  localparam int CW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [A-1:0]     a_mag;
  logic [B-1:0]     b_mag;
  logic             sign;
  logic [MUL_O-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [A-1:0]     in_a_mag;
  logic [B-1:0]     in_b_mag;
  logic [MUL_O-1:0] addend;
  logic [MUL_O-1:0] acc_next;

  // Magnitudes are kept unsigned at the operand width: the most negative
  // value negates to itself as a bit pattern, which read unsigned is exactly
  // 2^(W-1), so no extra bit is needed.
  always_comb begin
    in_a_mag = i_a;
    in_b_mag = i_b;
    if (i_a[A-1]) in_a_mag = ~i_a + A'(1);
    if (i_b[B-1]) in_b_mag = ~i_b + B'(1);
  end

  // One shift-add step: |a| weighted by the current bit position of |b|.
  always_comb begin
    addend = '0;
    if (b_mag[cnt]) addend = MUL_O'(a_mag) << cnt;
    acc_next = acc + addend;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_IDLE;
      a_mag   <= '0;
      b_mag   <= '0;
      sign    <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_mul   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_valid) begin
            a_mag <= in_a_mag;
            b_mag <= in_b_mag;
            sign  <= i_a[A-1] ^ i_b[B-1];
            acc   <= '0;
            cnt   <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc <= acc_next;
          if (cnt == CW'(B - 1)) begin
            // A zero magnitude negates to zero, so no negative zero arises.
            o_mul   <= sign ? (~acc_next + MUL_O'(1)) : acc_next;
            o_valid <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready = (state == S_IDLE);
  assign o_busy  = (state == S_BUSY);

endmodule

// File: doc/fxp_seq_mul.md
FXP_SEQ_MUL -- requirements
Module: fxp_seq_mul

Interface
REQ-001 The block SHALL have parameter A, default 8, meaning the width of operand a (signed two's complement).
REQ-002 The block SHALL have parameter B, default 8, meaning the width of operand b (signed two's complement).
REQ-003 The block SHALL have parameter MUL_O, default A+B, meaning the product width; no other value is supported.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_valid, input, 1 bit: operand pair offered.
REQ-007 The block SHALL have port o_ready, output, 1 bit: block can accept operands.
REQ-008 The block SHALL have port i_a, input, A bits: signed multiplicand.
REQ-009 The block SHALL have port i_b, input, B bits: signed multiplier.
REQ-010 The block SHALL have port o_valid, output, 1 bit: product available.
REQ-011 The block SHALL have port i_ready, input, 1 bit: consumer accepts the product.
REQ-012 The block SHALL have port o_mul, output, MUL_O bits: signed product a*b, registered.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high in BUSY state, for debug.

Function
REQ-014 The block SHALL implement states IDLE, BUSY and DONE.
REQ-015 IDLE: o_ready=1; on an edge with i_valid=1, the block SHALL capture i_a and i_b, record the sign (a_msb XOR b_msb), and load magnitudes |a| and |b| as unsigned values of A and B bits.
REQ-016 On capture, the block SHALL clear the accumulator and iteration counter, then go to BUSY.
REQ-017 BUSY: each edge SHALL process one bit of |b|, LSB first, using shift-add: if the bit is 1, add |a| shifted left by the iteration index.
REQ-018 The counter SHALL run 0..B-1; on the edge processing bit B-1, the block SHALL write the final magnitude to o_mul, two's-complement negated if the recorded sign is 1, and go to DONE.
REQ-019 Latency SHALL be exactly B rising edges from the accepting edge to o_valid=1; A=B=8 gives 8.
REQ-020 DONE: o_valid=1 and o_mul SHALL hold stable until an edge with i_ready=1; that edge SHALL go to IDLE with o_valid=0.
REQ-021 o_ready SHALL be 0 in BUSY and DONE; i_valid, i_a and i_b SHALL be ignored there and no operands captured.
REQ-022 No bypass: after a handshake the next operand acceptance SHALL occur no earlier than the following edge; peak throughput is one product per B+2 cycles.
REQ-023 |a| for a = -2^(A-1) SHALL be represented as the unsigned value 2^(A-1) without overflow; the same applies to b.
REQ-024 The product SHALL be exact for all operand pairs, with no saturation or rounding; in Qn.f formats the binary point of o_mul is at fa+fb.
REQ-025 A zero operand SHALL still take the full B cycles and produce o_mul=0, never negative zero.
REQ-026 o_mul SHALL change only on the final BUSY edge and SHALL keep its last value through IDLE.

Reset
REQ-027 When i_reset=1 on an edge, the block SHALL go to IDLE with o_valid=0, o_ready=1 (combinational from IDLE), o_busy=0, o_mul=0, accumulator and counter 0.
REQ-028 Reset SHALL take priority over every transition, including mid-BUSY and in DONE with i_ready=1; any in-flight product SHALL be discarded and no o_valid pulse produced.
REQ-029 i_valid=1 during a reset edge SHALL NOT capture; capture requires a non-reset edge.

Verification
REQ-030 i_a=8'h30 (3.0 Q4.4), i_b=8'h14 (1.25 Q4.4) -> 8 edges later o_valid=1, o_mul=16'h03C0 (3.75 Q8.8).
REQ-031 i_a=8'hFC (-4), i_b=8'h02 (2) -> o_mul=16'hFFF8 (-8); also i_a=8'h02, i_b=8'hFC -> 16'hFFF8.
REQ-032 i_a=8'h80, i_b=8'h80 -> o_mul=16'h4000; i_a=8'h80, i_b=8'h7F -> 16'hC080.
REQ-033 Hold i_ready=0 for 5 cycles in DONE while toggling i_valid and i_a -> o_mul and o_valid stable, o_ready=0; i_ready=1 -> IDLE next edge.
REQ-034 i_reset=1 at BUSY iteration 4 -> no o_valid, o_mul=0, o_ready=1; a new pair after reset yields its correct product.
REQ-035 Random signed pairs (>=1000) with random i_valid and i_ready gaps -> every product equals the reference a*b, in order, with no drops or duplicates.
